// File: rtl/quad_pkg.sv
// Purpose : shared types, constants and the phase-to-{A,B} encoding for the
//           quadrature encoder emulator.
// Contents: state_t (ST_IDLE / ST_RUN), DIR_UP / DIR_DN, gray2().
package quad_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Phase p walks 0,1,2,3; {A,B} walks 00,01,11,10 so only one bit moves per step.
    function automatic logic [1:0] gray2(input logic [1:0] p);
        return {p[1], p[1] ^ p[0]};
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Purpose : loadable down-counter that times the hold between quadrature edges.
// Ports   : clk, rst_n      clock / async active-low reset
//           load, value    load value on this edge (has priority over en)
//           en             count down by one while non-zero
//           zero           counter currently holds zero
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [DWELL_W-1:0] value,
    input  logic               en,
    output logic               zero
);

    logic [DWELL_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && (count != '0)) begin
            count <= count - DWELL_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/quad_encoder_gen.sv
// Purpose : quadrature encoder emulator. Turns burst step commands
//           (direction + count) into a Gray-coded quadA/quadB waveform with a
//           programmable dwell per phase and tracks net emitted steps.
// Ports   : clk, rst_n                    clock / async active-low reset
//           cmd_valid, cmd_ready         command handshake
//           cmd_dir, cmd_count           1 = up, 0 = down; steps to emit
//           abort                        stop the burst after the current dwell
//           quadA, quadB                 registered quadrature outputs
//           position                     signed net step count, wraps
//           busy                         burst in progress (= ~cmd_ready)
//           done                         one-cycle pulse at burst / abort completion
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for a command; cmd_ready high
// ST_RUN  | emitting steps; an edge each time the dwell timer reaches zero
module quad_encoder_gen
    import quad_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int DWELL_W      = 8,
    parameter int CNT_W        = 8,
    parameter int POS_W        = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             cmd_ready,
    input  logic             abort,
    output logic             quadA,
    output logic             quadB,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             done
);

    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);

    state_t           state,     stateNext;
    logic [1:0]       phase,     phaseNext;
    logic [1:0]       abReg;
    logic [CNT_W-1:0] remaining, remNext;
    logic [POS_W-1:0] posReg,    posNext;
    logic             dirReg,    dirNext;
    logic             doneReg,   doneNext;

    logic               tmrLoad;
    logic               tmrEn;
    logic [DWELL_W-1:0] tmrValue;
    logic               dwellZero;

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) uDwell (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmrLoad),
        .value (tmrValue),
        .en    (tmrEn),
        .zero  (dwellZero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase     <= 2'd0;
            abReg     <= 2'b00;
            remaining <= '0;
            posReg    <= '0;
            dirReg    <= DIR_UP;
            doneReg   <= 1'b0;
        end else begin
            state     <= stateNext;
            phase     <= phaseNext;
            // {A,B} is registered directly so no output is a function of two
            // flops that change together (phase 1->2 flips both bits).
            abReg     <= gray2(phaseNext);
            remaining <= remNext;
            posReg    <= posNext;
            dirReg    <= dirNext;
            doneReg   <= doneNext;
        end
    end

    always_comb begin
        stateNext = state;
        phaseNext = phase;
        remNext   = remaining;
        posNext   = posReg;
        dirNext   = dirReg;
        doneNext  = 1'b0;
        tmrLoad   = 1'b0;
        tmrEn     = 1'b0;
        tmrValue  = '0;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    dirNext = cmd_dir;
                    if (cmd_count == '0) begin
                        doneNext = 1'b1;
                    end else begin
                        stateNext = ST_RUN;
                        remNext   = cmd_count;
                        tmrLoad   = 1'b1;
                        tmrValue  = '0;
                    end
                end
            end

            ST_RUN: begin
                if (dwellZero && (remaining != '0)) begin
                    if (dirReg == DIR_UP) begin
                        phaseNext = phase + 2'd1;
                        posNext   = posReg + POS_W'(1);
                    end else begin
                        phaseNext = phase - 2'd1;
                        posNext   = posReg - POS_W'(1);
                    end
                    // Abort still lets this step out; it only cancels later ones.
                    remNext  = abort ? '0 : (remaining - CNT_W'(1));
                    tmrLoad  = 1'b1;
                    tmrValue = DWELL_LOAD;
                end else if (!dwellZero) begin
                    tmrEn = 1'b1;
                    if (abort) begin
                        remNext = '0;
                    end
                end else begin
                    stateNext = ST_IDLE;
                    doneNext  = 1'b1;
                end
            end

            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    assign quadA     = abReg[1];
    assign quadB     = abReg[0];
    assign position  = posReg;
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign done      = doneReg;

endmodule

// File: tb/tb_quad_encoder_gen.sv
module tb_quad_encoder_gen;

    localparam int D       = 4;
    localparam int DWELL_W = 8;
    localparam int CNT_W   = 8;
    localparam int POS_W   = 9;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_dir = 1'b0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             abort = 1'b0;
    logic             cmd_ready, quadA, quadB, busy, done;
    logic [POS_W-1:0] position;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    quad_encoder_gen #(
        .DWELL_CYCLES (D),
        .DWELL_W      (DWELL_W),
        .CNT_W        (CNT_W),
        .POS_W        (POS_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_dir   (cmd_dir),
        .cmd_count (cmd_count),
        .cmd_ready (cmd_ready),
        .abort     (abort),
        .quadA     (quadA),
        .quadB     (quadB),
        .position  (position),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Paddle-decoder model plus waveform sanity monitors.
    logic [1:0] prevAB = 2'b00;
    int decCount = 0;
    int upSteps = 0;
    int dnSteps = 0;
    int twoBitErrs = 0;
    int busyErrs = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prevAB   = 2'b00;
            decCount = 0;
            upSteps  = 0;
            dnSteps  = 0;
        end else begin
            if (busy !== ~cmd_ready) busyErrs++;
            if ({quadA, quadB} != prevAB) begin
                if (({quadA, quadB} ^ prevAB) == 2'b11) begin
                    twoBitErrs++;
                end else if (prevAB[1] ^ quadB) begin
                    decCount++;
                    upSteps++;
                end else begin
                    decCount--;
                    dnSteps++;
                end
                prevAB = {quadA, quadB};
            end
        end
    end

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Offers a command at a negedge; index k counts negedges after edge E_k (E0 = accept).
    task automatic runBurst(input bit dir, input int cnt, input int abortAt,
                            output int doneAt, output int edges, output int firstEdge,
                            output int readyErr);
        logic [1:0] prev;
        @(negedge clk);
        prev      = {quadA, quadB};
        cmd_valid = 1'b1;
        cmd_dir   = dir;
        cmd_count = CNT_W'(cnt);
        abort     = (abortAt == 0);
        doneAt    = -1;
        edges     = 0;
        firstEdge = -1;
        readyErr  = 0;
        for (int k = 0; k < 6000; k++) begin
            @(negedge clk);
            if (k == 0) cmd_valid = 1'b0;
            abort = (k + 1 == abortAt);
            if ({quadA, quadB} != prev) begin
                edges++;
                if (firstEdge < 0) firstEdge = k;
                prev = {quadA, quadB};
            end
            if (done) begin
                doneAt = k;
                break;
            end
            if (cmd_ready) readyErr++;
        end
        abort = 1'b0;
    endtask

    typedef struct {
        bit         doReset;
        bit         dir;
        int         cnt;
        int         abortAt;
        int         expDone;
        int         expEdges;
        int         expFirst;
        logic [8:0] expPos;
        logic [1:0] expAB;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int doneAt, edges, firstEdge, readyErr, doneAt2;
        logic [1:0] prev;
        bit sawDone;

        vecs[0] = '{0, 1'b1,   3, -1,   13,   3,  1, 9'h003, 2'b10};
        vecs[1] = '{1, 1'b0,   5, -1,   21,   5,  1, 9'h1FB, 2'b10};
        vecs[2] = '{0, 1'b1,   0, -1,    0,   0, -1, 9'h1FB, 2'b10};
        vecs[3] = '{0, 1'b1,  10,  2,    5,   1,  1, 9'h1FC, 2'b00};
        vecs[4] = '{0, 1'b0,   2,  0,    9,   2,  1, 9'h1FA, 2'b11};
        vecs[5] = '{0, 1'b1,   1, -1,    5,   1,  1, 9'h1FB, 2'b10};
        vecs[6] = '{0, 1'b1,   6,  5,    9,   2,  1, 9'h1FD, 2'b01};
        vecs[7] = '{0, 1'b0, 255, -1, 1021, 255,  1, 9'h0FE, 2'b11};

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_quadA", 32'(quadA), 32'd0);
        check("rst_quadB", 32'(quadB), 32'd0);
        check("rst_position", 32'(position), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed burst table
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].doReset) applyReset();
            runBurst(vecs[i].dir, vecs[i].cnt, vecs[i].abortAt, doneAt, edges, firstEdge, readyErr);
            check($sformatf("v%0d_done_at", i), 32'(doneAt), 32'(vecs[i].expDone));
            check($sformatf("v%0d_edges", i), 32'(edges), 32'(vecs[i].expEdges));
            check($sformatf("v%0d_first_edge", i), 32'(firstEdge), 32'(vecs[i].expFirst));
            check($sformatf("v%0d_ready_low_while_busy", i), 32'(readyErr), 32'd0);
            check($sformatf("v%0d_ready_at_done", i), 32'(cmd_ready), 32'd1);
            check($sformatf("v%0d_position", i), 32'(position), 32'(vecs[i].expPos));
            check($sformatf("v%0d_ab", i), 32'({quadA, quadB}), 32'(vecs[i].expAB));
            @(negedge clk);
            check($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'd0);
        end

        // cmd_valid held through a burst: ignored while busy, taken right after done
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_count = 8'd2;
        prev      = {quadA, quadB};
        edges     = 0;
        doneAt    = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 3) cmd_count = 8'd3;
            if ({quadA, quadB} != prev) begin
                edges++;
                prev = {quadA, quadB};
            end
            if (done) begin
                doneAt = k;
                break;
            end
        end
        check("held_first_done_at", 32'(doneAt), 32'd9);
        check("held_first_edges", 32'(edges), 32'd2);
        @(negedge clk);
        check("held_reaccept", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        edges   = 0;
        doneAt2 = -1;
        for (int k = 11; k < 80; k++) begin
            @(negedge clk);
            if ({quadA, quadB} != prev) begin
                edges++;
                prev = {quadA, quadB};
            end
            if (done) begin
                doneAt2 = k;
                break;
            end
        end
        check("held_second_done_at", 32'(doneAt2), 32'd23);
        check("held_second_edges", 32'(edges), 32'd3);
        check("held_position", 32'(position), 32'h103);
        check("held_ab", 32'({quadA, quadB}), 32'(2'b10));

        // Loopback into decoder model: 40 up, 10 down
        applyReset();
        runBurst(1'b1, 40, -1, doneAt, edges, firstEdge, readyErr);
        runBurst(1'b0, 10, -1, doneAt, edges, firstEdge, readyErr);
        @(negedge clk);
        check("loop_decoder_count", 32'(decCount), 32'd30);
        check("loop_up_steps", 32'(upSteps), 32'd40);
        check("loop_dn_steps", 32'(dnSteps), 32'd10);
        check("loop_position", 32'(position), 32'd30);

        // Position wrap at 2**POS_W
        applyReset();
        runBurst(1'b1, 255, -1, doneAt, edges, firstEdge, readyErr);
        runBurst(1'b1, 255, -1, doneAt, edges, firstEdge, readyErr);
        runBurst(1'b1, 1, -1, doneAt, edges, firstEdge, readyErr);
        check("wrap_pos_1ff", 32'(position), 32'h1FF);
        check("wrap_ab_511", 32'({quadA, quadB}), 32'(2'b10));
        runBurst(1'b1, 1, -1, doneAt, edges, firstEdge, readyErr);
        check("wrap_pos_zero", 32'(position), 32'd0);
        check("wrap_ab_00", 32'({quadA, quadB}), 32'(2'b00));

        // Async reset mid-burst
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_dir   = 1'b1;
        cmd_count = 8'd10;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_ab_before", 32'({quadA, quadB}), 32'(2'b11));
        rst_n = 1'b0;
        #1;
        check("midrst_ab", 32'({quadA, quadB}), 32'(2'b00));
        check("midrst_position", 32'(position), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        check("midrst_no_done", 32'(sawDone), 32'd0);
        runBurst(1'b1, 1, -1, doneAt, edges, firstEdge, readyErr);
        check("midrst_after_done_at", 32'(doneAt), 32'd5);
        check("midrst_after_position", 32'(position), 32'd1);
        check("midrst_after_ab", 32'({quadA, quadB}), 32'(2'b01));

        check("one_bit_per_edge", 32'(twoBitErrs), 32'd0);
        check("busy_is_not_ready", 32'(busyErrs), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
